// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word requests over
// req/gnt + rvalid, buffers returned words with their PCs in an in-order
// queue and hands them to decode over valid/ready. A redirect flushes the
// queue and drops every response still in flight.

package inst_prefetch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ipq_entry_t;

  localparam logic [31:0] IPQ_NOP = 32'h0000_0013;
endpackage

// One queue slot: a write-enabled register holding {pc, inst}.
module ipq_slot
  import inst_prefetch_queue_pkg::*;
(
  input  logic       CK_REF,
  input  logic       int_rst_n,
  input  logic       wr_en,
  input  ipq_entry_t wr_data,
  output ipq_entry_t q
);

  // Capture the pushed entry; contents are don't-care while the slot is unused.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n)  q <= '0;
    else if (wr_en)  q <= wr_data;
  end

endmodule

module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        CK_REF,
  input  logic        int_rst_n,
  input  logic        HALT,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        DEC_VALID,
  output logic [31:0] DEC_INST,
  output logic [31:0] DEC_PC,
  input  logic        DEC_READY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = '0;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  logic [CW-1:0] count, outstanding, discard;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fetch_pc, resp_pc;
  logic [CW:0]   reserved;
  logic [31:0]   redirect_pc;

  logic grant, rsp, push, pop;

  ipq_entry_t [DEPTH-1:0] slot_q;
  logic       [DEPTH-1:0] slot_we;
  ipq_entry_t             push_entry, head;

  // Low bits of the redirect target are forced to a word boundary.
  assign redirect_pc = REDIRECT_PC & 32'hFFFF_FFFC;

  // Queue slots plus in-flight requests; a request only issues if its
  // response already has a slot reserved, so the queue cannot overflow.
  assign reserved = {1'b0, count} + {1'b0, outstanding};

  // Reset gates the request directly so it drops the instant reset asserts.
  assign IMEM_REQ  = int_rst_n && !HALT && !REDIRECT_VALID &&
                     (reserved < DEPTH_C) && (outstanding < MAXO_C);
  assign IMEM_ADDR = fetch_pc;

  assign grant = IMEM_REQ && IMEM_GNT;
  // A stray rvalid with nothing in flight is not a response.
  assign rsp   = IMEM_RVALID && (outstanding != ZERO_C);
  assign push  = rsp && (discard == ZERO_C) && !REDIRECT_VALID;
  assign pop   = DEC_VALID && DEC_READY && !HALT && !REDIRECT_VALID;

  assign push_entry = '{pc: resp_pc, inst: IMEM_RDATA};

  // Storage array: one slot per entry, written at the tail pointer.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr == PW'(i));
    ipq_slot u_slot (
      .CK_REF    (CK_REF),
      .int_rst_n (int_rst_n),
      .wr_en     (slot_we[i]),
      .wr_data   (push_entry),
      .q         (slot_q[i])
    );
  end

  // Decode side is driven purely from registered state (no path from DEC_READY).
  assign head      = slot_q[rd_ptr];
  assign DEC_VALID = (count != ZERO_C);
  assign DEC_INST  = DEC_VALID ? head.inst : IPQ_NOP;
  assign DEC_PC    = DEC_VALID ? head.pc   : resp_pc;

  // In-flight request counter: grant increments, response decrements.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      outstanding <= '0;
    end else begin
      case ({grant, rsp})
        2'b10:   outstanding <= outstanding + ONE_C;
        2'b01:   outstanding <= outstanding - ONE_C;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Discard counter: a redirect marks everything still in flight after this
  // cycle's response as stale; since discard never exceeds outstanding this
  // also covers back-to-back redirects without double counting.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      discard <= '0;
    end else if (REDIRECT_VALID) begin
      discard <= rsp ? (outstanding - ONE_C) : outstanding;
    end else if (rsp && (discard != ZERO_C)) begin
      discard <= discard - ONE_C;
    end
  end

  // Queue occupancy and pointers; redirect empties the queue.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (REDIRECT_VALID) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE_C;
      if (pop)  rd_ptr <= rd_ptr + PONE_C;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Fetch PC advances per grant; response PC advances per kept word.
  always_ff @(posedge CK_REF or negedge int_rst_n) begin
    if (!int_rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (REDIRECT_VALID) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push)  resp_pc  <= resp_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: a memory model with programmable latency
// answers grants; each grant pushes the expected {pc, inst} onto a
// scoreboard that is popped and compared when decode takes a word.
module tb_inst_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CK_REF = 1'b0;
  logic        int_rst_n = 1'b0;
  logic        HALT = 1'b0, REDIRECT_VALID = 1'b0, IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0, DEC_READY = 1'b0;
  logic [31:0] REDIRECT_PC = '0, IMEM_RDATA = '0;
  logic        IMEM_REQ, DEC_VALID;
  logic [31:0] IMEM_ADDR, DEC_INST, DEC_PC;

  inst_prefetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)) dut (
    .CK_REF         (CK_REF),
    .int_rst_n      (int_rst_n),
    .HALT           (HALT),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_GNT       (IMEM_GNT),
    .IMEM_RVALID    (IMEM_RVALID),
    .IMEM_RDATA     (IMEM_RDATA),
    .DEC_VALID      (DEC_VALID),
    .DEC_INST       (DEC_INST),
    .DEC_PC         (DEC_PC),
    .DEC_READY      (DEC_READY)
  );

  always #5 CK_REF = ~CK_REF;

  typedef struct { int unsigned due; logic [31:0] data; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct {
    logic halt, redir, ready;
    logic exp_req, exp_dv;
    logic [31:0] exp_addr, exp_inst, exp_pc;
  } vec_t;

  mem_t mq[$];
  exp_t sb[$];

  logic        halt, redir, ready, gnt, stray_rv;
  logic [31:0] redir_pc, exp_addr, key, last_pop_pc;
  int unsigned cyc, lat;
  int          n_chk, n_fail, n_pops;

  logic        s_req, s_dv, granted;
  logic [31:0] s_addr, s_dinst, s_dpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, sample outputs before the edge, update the
  // scoreboard, then step past the rising edge.
  task automatic cycle();
    mem_t  m;
    exp_t  e;
    int unsigned d;
    IMEM_RVALID = 1'b0;
    IMEM_RDATA  = $urandom;
    if (stray_rv) begin
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = 32'hDEAD_BEEF;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      IMEM_RVALID = 1'b1;
      IMEM_RDATA  = m.data;
    end
    IMEM_GNT = gnt; HALT = halt; REDIRECT_VALID = redir;
    REDIRECT_PC = redir_pc; DEC_READY = ready;
    #1;
    s_req = IMEM_REQ; s_addr = IMEM_ADDR; s_dv = DEC_VALID;
    s_dinst = DEC_INST; s_dpc = DEC_PC;
    granted = s_req && gnt;
    if (!s_dv) begin
      chk("nop_when_empty", s_dinst, NOP);
      chk("empty_dec_pc", s_dpc, (sb.size() != 0) ? sb[0].pc : exp_addr);
    end else if (ready && !halt && !redir) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pop: got pc %h, expected no valid word (cycle %0d)", s_dpc, cyc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", s_dpc, e.pc);
        chk("pop_inst", s_dinst, e.inst);
        last_pop_pc = s_dpc;
        n_pops++;
      end
    end
    if (granted) begin
      chk("grant_addr", s_addr, exp_addr);
      d = cyc + lat;
      if (mq.size() != 0 && d <= mq[$].due) d = mq[$].due + 1;
      mq.push_back('{due: d, data: s_addr ^ key});
      sb.push_back('{pc: exp_addr, inst: exp_addr ^ key});
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      sb.delete();
      exp_addr = redir_pc & 32'hFFFF_FFFC;
    end
    @(posedge CK_REF);
    #2;
    cyc++;
  endtask

  // Async reset: outputs must take reset values immediately.
  task automatic do_reset();
    int_rst_n = 1'b0;
    halt = 0; redir = 0; stray_rv = 0; redir_pc = '0;
    HALT = 0; REDIRECT_VALID = 0; IMEM_RVALID = 0;
    #1;
    chk("rst_req", IMEM_REQ, 1'b0);
    chk("rst_addr", IMEM_ADDR, RESET_PC);
    chk("rst_dv", DEC_VALID, 1'b0);
    chk("rst_inst", DEC_INST, NOP);
    chk("rst_pc", DEC_PC, RESET_PC);
    mq.delete();
    sb.delete();
    exp_addr = RESET_PC;
    #9;
    int_rst_n = 1'b1;
  endtask

  // Stop granting and let decode empty everything that is in flight.
  task automatic drain(input string name);
    gnt = 0; ready = 1; halt = 0; redir = 0;
    for (int i = 0; i < 60 && (sb.size() != 0 || mq.size() != 0); i++) cycle();
    chk(name, sb.size() + mq.size(), 0);
  endtask

  vec_t vecs[5];
  int   ng, p0;
  logic found;

  initial begin
    n_chk = 0; n_fail = 0; n_pops = 0; cyc = 0; lat = 1; key = '0;
    gnt = 0; ready = 0; halt = 0; redir = 0; stray_rv = 0;
    redir_pc = '0; exp_addr = RESET_PC; last_pop_pc = '0;
    #2;
    do_reset();

    // Request gating from the idle reset state, no grants.
    vecs[0] = '{0, 0, 0, 1, 0, RESET_PC, NOP, RESET_PC};
    vecs[1] = '{1, 0, 0, 0, 0, RESET_PC, NOP, RESET_PC};
    vecs[2] = '{0, 1, 0, 0, 0, RESET_PC, NOP, RESET_PC};
    vecs[3] = '{1, 1, 1, 0, 0, RESET_PC, NOP, RESET_PC};
    vecs[4] = '{0, 0, 1, 1, 0, RESET_PC, NOP, RESET_PC};
    for (int i = 0; i < 5; i++) begin
      halt = vecs[i].halt; redir = vecs[i].redir; ready = vecs[i].ready;
      gnt = 0; redir_pc = RESET_PC;
      cycle();
      chk("vec_req", s_req, vecs[i].exp_req);
      chk("vec_addr", s_addr, vecs[i].exp_addr);
      chk("vec_dv", s_dv, vecs[i].exp_dv);
      chk("vec_inst", s_dinst, vecs[i].exp_inst);
      chk("vec_pc", s_dpc, vecs[i].exp_pc);
    end
    halt = 0; redir = 0;

    // Streaming: one word per cycle from cycle 2, RDATA = address.
    do_reset();
    key = '0; lat = 1; gnt = 1; ready = 1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("stream_dv", s_dv, (k >= 2) ? 1'b1 : 1'b0);
    end

    // HALT with one response in flight: request withdrawn, head frozen.
    key = 32'h5A5A_0F0F;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle();
      if (mq.size() == 1) found = 1;
    end
    chk("halt_setup", found, 1'b1);
    halt = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("halt_req", s_req, 1'b0);
      chk("halt_dv", s_dv, 1'b1);
      chk("halt_pc", s_dpc, sb[0].pc);
      chk("halt_inst", s_dinst, sb[0].inst);
    end
    chk("halt_rsp_landed", mq.size(), 0);
    halt = 0;
    for (int i = 0; i < 10; i++) cycle();

    // Redirect with two requests in flight at 3-cycle latency.
    lat = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (mq.size() == 2) found = 1;
    end
    chk("redir_two_outstanding", found, 1'b1);
    redir = 1; redir_pc = 32'h0000_0103;
    cycle();
    chk("redir_req", s_req, 1'b0);
    redir = 0;
    cycle();
    chk("redir_dv_next", s_dv, 1'b0);
    chk("redir_addr", s_addr, 32'h0000_0100);
    p0 = n_pops;
    for (int i = 0; i < 12 && n_pops == p0; i++) cycle();
    chk("redir_pop_seen", (n_pops > p0) ? 1 : 0, 1);
    chk("redir_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect during HALT to the top of the address space; PC wraps to 0.
    lat = 1; key = 32'h1234_5678;
    halt = 1; redir = 1; redir_pc = 32'hFFFF_FFF8;
    cycle();
    chk("wrap_redir_req", s_req, 1'b0);
    halt = 0; redir = 0;
    p0 = n_pops;
    for (int i = 0; i < 12 && (n_pops - p0) < 4; i++) cycle();
    chk("wrap_pops", ((n_pops - p0) >= 4) ? 1 : 0, 1);
    drain("drain_wrap");

    // Decode stalled: exactly four grants fill the queue, then fetch resumes at 0x10.
    do_reset();
    lat = 1; gnt = 1; ready = 0; ng = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (granted) ng++;
    end
    chk("full_grants", ng, 4);
    chk("full_req_off", s_req, 1'b0);
    ready = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (granted) found = 1;
    end
    chk("full_resume_seen", found, 1'b1);
    chk("full_resume_addr", s_addr, 32'h0000_0010);
    drain("drain_full");

    // Grant withheld: request and address held stable until granted.
    do_reset();
    gnt = 1; ready = 1;
    cycle(); cycle();
    gnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("nogrant_req", s_req, 1'b1);
      chk("nogrant_addr", s_addr, 32'h0000_0008);
    end
    gnt = 1;
    cycle();
    chk("grant_taken", granted, 1'b1);
    cycle();
    chk("grant_advance", s_addr, 32'h0000_000C);
    for (int i = 0; i < 4; i++) cycle();

    // Async reset mid-stream, then a stray rvalid that must be ignored.
    do_reset();
    gnt = 1; ready = 1; stray_rv = 1;
    cycle();
    stray_rv = 0;
    for (int i = 0; i < 8; i++) cycle();
    drain("drain_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
